lfsr25_gen: RTL and testbench



---
 rtl/lbm_rng_pkg.sv | 30 +++
 rtl/lfsr25_gen_if.sv | 29 ++
 rtl/lfsr25_gen.sv | 98 +++++++++
 tb/tb_lfsr25_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lbm_rng_pkg.sv
// ============================================================================
// Module   : lbm_rng_pkg
// Purpose  : Shared constants, FSM type and next-state function for the
//            25-bit LBM random-number LFSR source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lbm_rng_pkg;

    localparam int LFSR_W = 25;
    localparam int TAP_HI = 24;
    localparam int TAP_LO = 21;

    localparam logic [LFSR_W-1:0] C_DEFAULT_SEED = 25'h1ACE5ED;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } lfsr_fsm_e;

    // Fibonacci step for x^25 + x^22 + 1: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr25_gen_if.sv
// ============================================================================
// Module   : lfsr25_gen_if
// Purpose  : Valid/ready word port from the LFSR source to the scrambler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr25_gen_if;
    import lbm_rng_pkg::*;

    logic signed [LFSR_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

`default_nettype wire

// File: rtl/lfsr25_gen.sv
// ============================================================================
// Module   : lfsr25_gen
// Purpose  : Maximal-length 25-bit Fibonacci LFSR word source with seeding,
//            enable, accepted-word counter and all-zero lockup recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr25_gen
    import lbm_rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = C_DEFAULT_SEED,
    parameter int                CNT_W        = 32
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              enable,
    input  wire logic              seed_load,
    input  wire logic [LFSR_W-1:0] seed_in,
    lfsr25_gen_if.master           out_if,
    output logic [CNT_W-1:0]       word_count,
    output logic                   lockup_err
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] r_out_data;
    logic              r_out_valid;
    lfsr_fsm_e         r_fsm;
    logic [CNT_W-1:0]  r_word_count;
    logic              r_lockup_err;

    logic w_xfer;
    logic w_lockup;

    assign w_xfer   = r_out_valid & out_if.out_ready;
    assign w_lockup = (r_fsm != ST_IDLE) && (r_state == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= DEFAULT_SEED;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_fsm        <= ST_IDLE;
            r_word_count <= '0;
            r_lockup_err <= 1'b0;
        end else if (seed_load) begin
            // A pending word is dropped here even if it is being accepted.
            r_state      <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
            r_lockup_err <= 1'b0;
            r_fsm        <= ST_PRIME;
        end else if (w_lockup) begin
            r_state      <= DEFAULT_SEED;
            r_lockup_err <= 1'b1;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (enable) begin
                        r_fsm <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    r_out_data  <= r_state;
                    r_state     <= lfsr_next(r_state);
                    r_out_valid <= 1'b1;
                    r_fsm       <= ST_RUN;
                end
                ST_RUN: begin
                    // Without a transfer the presented word is held unchanged.
                    if (w_xfer) begin
                        r_word_count <= r_word_count + 1'b1;
                        if (enable) begin
                            r_out_data <= r_state;
                            r_state    <= lfsr_next(r_state);
                        end else begin
                            r_out_valid <= 1'b0;
                            r_fsm       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_fsm       <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_if.out_data  = $signed(r_out_data);
    assign out_if.out_valid = r_out_valid;
    assign word_count       = r_word_count;
    assign lockup_err       = r_lockup_err;

endmodule

`default_nettype wire

// File: tb/tb_lfsr25_gen.sv
// ============================================================================
// Module   : tb_lfsr25_gen
// Purpose  : Self-checking bench for lfsr25_gen: vector table plus directed
//            multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr25_gen;

    localparam logic [24:0] C_DEF = 25'h1ACE5ED;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        seed_load;
    logic [24:0] seed_in;
    logic [31:0] word_count;
    logic        lockup_err;

    int n_checks;
    int n_fail;

    lfsr25_gen_if bus ();

    lfsr25_gen #(
        .DEFAULT_SEED (C_DEF),
        .CNT_W        (32)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .out_if     (bus.master),
        .word_count (word_count),
        .lockup_err (lockup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        sl;
        logic [24:0] seed;
        logic        exp_valid;
        logic [24:0] exp_data;
        logic [31:0] exp_cnt;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[14];

    // Independent reference step for x^25 + x^22 + 1.
    function automatic logic [24:0] ref_next(input logic [24:0] s);
        return {s[23:0], s[24] ^ s[21]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic sl, input logic [24:0] sd);
        enable        = en;
        bus.out_ready = rdy;
        seed_load     = sl;
        seed_in       = sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic v, input logic [24:0] d,
                              input logic [31:0] c, input logic l);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        if (v) check({tag, ".data"}, {7'd0, bus.out_data}, {7'd0, d});
        check({tag, ".count"}, word_count, c);
        check({tag, ".lock"}, {31'd0, lockup_err}, {31'd0, l});
    endtask

    logic [24:0] exp_w;
    logic [24:0] held;
    logic [31:0] cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //         en    rdy   sl    seed     valid data        cnt    lock
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b0, 25'h0,       32'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h1ACE5ED, 32'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h159CBDA, 32'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h0B397B5, 32'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h1672F6B, 32'd3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 25'h0, 1'b1, 25'h1672F6B, 32'd3, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 25'h0, 1'b1, 25'h1672F6B, 32'd3, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 25'h0, 1'b0, 25'h0,       32'd4, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 25'h0, 1'b0, 25'h0,       32'd4, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b0, 25'h0,       32'd4, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h0CE5ED6, 32'd4, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 25'h0, 1'b0, 25'h0,       32'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h1ACE5ED, 32'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 25'h0, 1'b1, 25'h159CBDA, 32'd1, 1'b0};

        drive(1'b0, 1'b0, 1'b0, 25'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset.data", {7'd0, bus.out_data}, 32'd0);
        check_port("reset", 1'b0, 25'h0, 32'd0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].sl, vecs[i].seed);
            tick();
            check_port($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                       vecs[i].exp_cnt, vecs[i].exp_lock);
        end

        // Seed 1: single bit walks up until tap 21 feeds back.
        drive(1'b1, 1'b1, 1'b1, 25'h0000001);
        tick();
        check_port("seed1.load", 1'b0, 25'h0, 32'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 25'h0);
        tick();
        exp_w = 25'h0000001;
        for (int k = 0; k < 23; k++) begin
            if (k < 22) check($sformatf("seed1.walk%0d", k), {7'd0, bus.out_data}, 32'd1 << k);
            else        check("seed1.fb", {7'd0, bus.out_data}, 32'h0400001);
            check($sformatf("seed1.cnt%0d", k), word_count, k);
            exp_w = ref_next(exp_w);
            tick();
        end
        check("seed1.cnt23", word_count, 32'd23);

        // Backpressure: word and count frozen, then resume without gap.
        held = bus.out_data;
        cnt  = word_count;
        check("bp.held_is_model", {7'd0, held}, {7'd0, exp_w});
        drive(1'b1, 1'b0, 1'b0, 25'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_port($sformatf("bp.stall%0d", k), 1'b1, held, cnt, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 25'h0);
        tick();
        check_port("bp.resume", 1'b1, ref_next(held), cnt + 1, 1'b0);
        held = ref_next(held);

        // Drop enable with a pending, unaccepted word.
        drive(1'b0, 1'b0, 1'b0, 25'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_port($sformatf("en_off.hold%0d", k), 1'b1, held, cnt + 1, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 25'h0);
        tick();
        check_port("en_off.accept", 1'b0, 25'h0, cnt + 2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 25'h0);
        tick();
        tick();
        check_port("en_on.first", 1'b1, ref_next(held), cnt + 2, 1'b0);
        held = ref_next(held);

        // Lockup: force an all-zero state while stalled in RUN.
        force dut.r_state = 25'h0;
        #1;
        release dut.r_state;
        tick();
        check_port("lock.detect", 1'b1, held, cnt + 2, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 25'h0);
        tick();
        check_port("lock.recover", 1'b1, C_DEF, cnt + 3, 1'b1);
        tick();
        check_port("lock.sticky", 1'b1, 25'h159CBDA, cnt + 4, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 25'h0ABCDEF);
        tick();
        check_port("lock.seedclr", 1'b0, 25'h0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 25'h0);
        tick();
        check_port("seedx.first", 1'b1, 25'h0ABCDEF, 32'd0, 1'b0);

        // Reset during a stalled transfer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_port("rst.mid", 1'b0, 25'h0, 32'd0, 1'b0);
        check("rst.mid.data", {7'd0, bus.out_data}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 25'h0);
        tick();
        tick();
        check_port("rst.restart", 1'b1, C_DEF, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
